octal_pulse_decoder: RTL and testbench

//  Sequential 3-to-8 decoder: accepts a 3-bit binary code over a valid/ready handshake and drives the matching
//  one-hot line of octal_out for PULSE_LEN cycles, then a GAP_LEN all-zero guard interval before the next code.

---
 rtl/octal_codec_pkg.sv | 20 ++
 rtl/octal_pulse_timer.sv | 38 +++
 rtl/octal_pulse_decoder.sv | 118 +++++++++++
 tb/tb_octal_pulse_decoder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/octal_codec_pkg.sv
// Shared types and helpers for the octal encoder/decoder pair.
// Provides the pulse FSM state enum, code/line widths and the one-hot helper.
package octal_codec_pkg;

   localparam int CODE_W = 3;
   localparam int LINE_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_e;

   function automatic logic [LINE_W-1:0] onehot8(
      input logic [CODE_W-1:0] code
   );
      return LINE_W'(1) << code;
   endfunction

endpackage

// File: rtl/octal_pulse_timer.sv
// Loadable 8-bit down-counter that saturates at zero.
// Ports: clk, rst_n, clear_i, load_i, load_val_i[7:0], en_i -> zero_o.
module octal_pulse_timer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear_i,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       en_i,
   output logic       zero_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   // clear wins over load, load wins over decrement
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = 8'h00;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (en_i && (cnt_q != 8'h00)) begin
         cnt_d = cnt_q - 8'h01;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'h00;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == 8'h00);

endmodule

// File: rtl/octal_pulse_decoder.sv
// Sequential 3-to-8 line-strobe driver: one-hot pulse per accepted code.
// Ports: clk, rst_n, sel, in_valid/in_ready, binary_in[2:0] -> octal_out[7:0], out_valid, busy, done.
module octal_pulse_decoder
   import octal_codec_pkg::*;
#(
   parameter int PULSE_LEN = 4,
   parameter int GAP_LEN   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sel,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CODE_W-1:0] binary_in,
   output logic [LINE_W-1:0] octal_out,
   output logic              out_valid,
   output logic              busy,
   output logic              done
);

   localparam logic [7:0] P_LOAD = 8'(PULSE_LEN - 1);
   localparam logic [7:0] G_LOAD = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'h00;

   state_e            state_q, state_d;
   logic [LINE_W-1:0] octal_q, octal_d;
   logic              valid_q, valid_d;

   logic       tmr_clear;
   logic       tmr_load;
   logic [7:0] tmr_val;
   logic       tmr_en;
   logic       tmr_zero;

   octal_pulse_timer u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (tmr_clear),
      .load_i    (tmr_load),
      .load_val_i(tmr_val),
      .en_i      (tmr_en),
      .zero_o    (tmr_zero)
   );

   always_comb begin
      state_d   = state_q;
      octal_d   = octal_q;
      valid_d   = valid_q;
      tmr_clear = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = 8'h00;
      tmr_en    = 1'b0;
      if (!sel) begin
         // dropping sel abandons any pulse in flight
         state_d   = IDLE;
         octal_d   = '0;
         valid_d   = 1'b0;
         tmr_clear = 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  state_d  = DRIVE;
                  octal_d  = onehot8(binary_in);
                  valid_d  = 1'b1;
                  tmr_load = 1'b1;
                  tmr_val  = P_LOAD;
               end
            end
            DRIVE: begin
               if (tmr_zero) begin
                  octal_d = '0;
                  valid_d = 1'b0;
                  if (GAP_LEN > 0) begin
                     state_d  = GAP;
                     tmr_load = 1'b1;
                     tmr_val  = G_LOAD;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tmr_en = 1'b1;
               end
            end
            GAP: begin
               if (tmr_zero) begin
                  state_d = IDLE;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               octal_d = '0;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         octal_q <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         octal_q <= octal_d;
         valid_q <= valid_d;
      end
   end

   assign in_ready  = sel & (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign done      = sel & (state_q == DRIVE) & tmr_zero;
   assign octal_out = octal_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_octal_pulse_decoder.sv
// Bench for octal_pulse_decoder: directed tables plus a timing-window reference model.
module tb_octal_pulse_decoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       sel, in_valid, in_ready, out_valid, busy, done;
   logic [2:0] binary_in;
   logic [7:0] octal_out;
   logic       sel1, iv1, rdy1, ov1, busy1, done1;
   logic [2:0] bin1;
   logic [7:0] oct1;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   octal_pulse_decoder dut (
      .clk(clk), .rst_n(rst_n), .sel(sel), .in_valid(in_valid),
      .in_ready(in_ready), .binary_in(binary_in), .octal_out(octal_out),
      .out_valid(out_valid), .busy(busy), .done(done)
   );

   octal_pulse_decoder #(.PULSE_LEN(1), .GAP_LEN(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .sel(sel1), .in_valid(iv1),
      .in_ready(rdy1), .binary_in(bin1), .octal_out(oct1),
      .out_valid(ov1), .busy(busy1), .done(done1)
   );

   typedef struct {
      logic [2:0] code;
      logic [7:0] exp;
   } vec_t;
   vec_t tab[8];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a pulse is a time window after the accept edge.
   localparam int P = 4;
   localparam int G = 1;
   int         cyc;
   int         acc;
   logic [2:0] mcode;
   bit         alive;

   function automatic bit m_drive(int j);
      return alive && j >= acc && j < acc + P;
   endfunction

   function automatic bit m_busy(int j);
      return alive && j >= acc && j < acc + P + G;
   endfunction

   task automatic rnd_cycle();
      logic [7:0] eo;
      sel       = ($urandom % 16) != 0;
      in_valid  = ($urandom % 2) != 0;
      binary_in = 3'($urandom);
      @(negedge clk);
      eo = m_drive(cyc) ? (8'd1 << mcode) : 8'h00;
      chk("rnd_octal", octal_out, eo);
      chk("rnd_valid", out_valid, m_drive(cyc));
      chk("rnd_busy", busy, m_busy(cyc));
      chk("rnd_ready", in_ready, sel && !m_busy(cyc));
      chk("rnd_done", done, sel && m_drive(cyc) && cyc == acc + P - 1);
      chk("rnd_onehot", ($countones(octal_out) <= 1), 1);
      @(posedge clk);
      if (!sel) begin
         alive = 1'b0;
      end else if (!m_busy(cyc) && in_valid) begin
         acc   = cyc + 1;
         mcode = binary_in;
         alive = 1'b1;
      end
      cyc++;
      #1;
   endtask

   initial begin
      tab[0] = '{3'd0, 8'h01};
      tab[1] = '{3'd1, 8'h02};
      tab[2] = '{3'd2, 8'h04};
      tab[3] = '{3'd3, 8'h08};
      tab[4] = '{3'd4, 8'h10};
      tab[5] = '{3'd5, 8'h20};
      tab[6] = '{3'd6, 8'h40};
      tab[7] = '{3'd7, 8'h80};

      // reset with inputs active
      rst_n = 1'b0; sel = 1'b1; in_valid = 1'b1; binary_in = 3'd5;
      sel1 = 1'b0; iv1 = 1'b0; bin1 = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_octal", octal_out, 8'h00);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1 chk("rst_ready", in_ready, 1);
      @(posedge clk); #1;

      // sweep all codes with default timing
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; binary_in = tab[i].code;
         @(negedge clk);
         chk("sw_ready", in_ready, 1);
         @(posedge clk); #1;
         in_valid = 1'b0; binary_in = ~tab[i].code;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("sw_octal", octal_out, tab[i].exp);
            chk("sw_valid", out_valid, 1);
            chk("sw_done", done, (c == 3));
            @(posedge clk); #1;
         end
         @(negedge clk);
         chk("sw_gap_octal", octal_out, 8'h00);
         chk("sw_gap_busy", busy, 1);
         chk("sw_gap_ready", in_ready, 0);
         @(posedge clk); #1;
      end

      // sel dropped in the second drive cycle
      in_valid = 1'b1; binary_in = 3'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("sd_octal1", octal_out, 8'h08);
      @(posedge clk); #1;
      sel = 1'b0;
      @(negedge clk);
      chk("sd_done", done, 0);
      chk("sd_ready0", in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("sd_octal", octal_out, 8'h00);
      chk("sd_valid", out_valid, 0);
      chk("sd_busy", busy, 0);
      chk("sd_ready1", in_ready, 0);
      sel = 1'b1;
      #1 chk("sd_ready2", in_ready, 1);
      @(posedge clk); #1;

      // single-cycle pulses, no gap, in_valid held
      sel1 = 1'b1; iv1 = 1'b1; bin1 = 3'd5;
      @(negedge clk);
      chk("p1_ready", rdy1, 1);
      @(posedge clk); #1;
      bin1 = 3'd6;
      @(negedge clk);
      chk("p1_oct5", oct1, 8'h20);
      chk("p1_done5", done1, 1);
      chk("p1_ready5", rdy1, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("p1_idle_oct", oct1, 8'h00);
      chk("p1_idle_rdy", rdy1, 1);
      @(posedge clk); #1;
      iv1 = 1'b0;
      @(negedge clk);
      chk("p1_oct6", oct1, 8'h40);
      chk("p1_done6", done1, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("p1_end", oct1, 8'h00);
      chk("p1_end_v", ov1, 0);
      chk("p1_end_b", busy1, 0);
      sel1 = 1'b0;

      // code change ignored, then async reset mid-pulse
      in_valid = 1'b1; binary_in = 3'd7;
      @(posedge clk); #1;
      binary_in = 3'd2;
      @(negedge clk);
      chk("ar_c1", octal_out, 8'h80);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ar_c2", octal_out, 8'h80);
      @(posedge clk); #1;
      @(negedge clk);
      chk("ar_c3", octal_out, 8'h80);
      #1 rst_n = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("ar_octal", octal_out, 8'h00);
      chk("ar_valid", out_valid, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("ar_rel_busy", busy, 0);
      chk("ar_rel_ready", in_ready, 1);
      chk("ar_rel_octal", octal_out, 8'h00);
      @(posedge clk); #1;

      // random traffic against the window model
      sel = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      cyc = 0; acc = -1000; mcode = 3'd0; alive = 1'b0;
      for (int k = 0; k < 10000; k++) begin
         rnd_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
